// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and default width.
package seq_divider_pkg;

    localparam int unsigned DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Counter width needed to hold the value WIDTH.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift one dividend bit into the partial remainder,
// compare against the divisor and conditionally subtract.
module seq_divider_div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             shift_in_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    logic           unused_diff_msb;

    // Trial value is WIDTH+1 bits so the compare never overflows.
    assign trial           = {rem_i, shift_in_i};
    assign diff            = trial - {1'b0, divisor_i};
    // A kept remainder is always below the divisor, so the top bit is zero.
    assign unused_diff_msb = diff[WIDTH];

    always_comb begin
        q_bit_o = (trial >= {1'b0, divisor_i});
        rem_o   = q_bit_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider; Start -> Done takes WIDTH+1 clocks.
// Optional DivZero flag port enabled by defining SEQ_DIV_ZERO_FLAG_EN.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder
`ifdef SEQ_DIV_ZERO_FLAG_EN
    ,
    output logic             DivZero
`endif
);

    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [WIDTH-1:0]  divisor_q, divisor_d;
    logic [WIDTH-1:0]  dq_q, dq_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  quot_out_q, quot_out_d;
    logic [WIDTH-1:0]  rem_out_q, rem_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef SEQ_DIV_ZERO_FLAG_EN
    logic              div_zero_q, div_zero_d;
`endif

    logic [WIDTH-1:0]  step_rem;
    logic              step_q_bit;

    seq_divider_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i      (rem_q),
        .shift_in_i (dq_q[WIDTH-1]),
        .divisor_i  (divisor_q),
        .rem_o      (step_rem),
        .q_bit_o    (step_q_bit)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        divisor_d  = divisor_q;
        dq_d       = dq_q;
        rem_d      = rem_q;
        quot_out_d = quot_out_q;
        rem_out_d  = rem_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef SEQ_DIV_ZERO_FLAG_EN
        div_zero_d = div_zero_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    divisor_d = Divisor;
                    dq_d      = Dividend;
                    rem_d     = '0;
                    count_d   = CntLoad;
                    busy_d    = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                // Dividend bits leave at the top of dq as quotient bits enter at the bottom.
                rem_d   = step_rem;
                dq_d    = {dq_q[WIDTH-2:0], step_q_bit};
                count_d = count_q - CntOne;
                if (count_q == CntOne) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                quot_out_d = dq_q;
                rem_out_d  = rem_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
`ifdef SEQ_DIV_ZERO_FLAG_EN
                div_zero_d = (divisor_q == '0);
`endif
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            divisor_q  <= '0;
            dq_q       <= '0;
            rem_q      <= '0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SEQ_DIV_ZERO_FLAG_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            divisor_q  <= divisor_d;
            dq_q       <= dq_d;
            rem_q      <= rem_d;
            quot_out_q <= quot_out_d;
            rem_out_q  <= rem_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SEQ_DIV_ZERO_FLAG_EN
            div_zero_q <= div_zero_d;
`endif
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Quotient  = quot_out_q;
    assign Remainder = rem_out_q;
`ifdef SEQ_DIV_ZERO_FLAG_EN
    assign DivZero   = div_zero_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results queued at Start, checked at Done.
module tb_seq_divider;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         Start = 1'b0;
    logic [W-1:0] Dividend = '0;
    logic [W-1:0] Divisor = '0;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
`ifdef SEQ_DIV_ZERO_FLAG_EN
    logic         DivZero;
`endif

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] held_q = '0;
    logic [W-1:0] held_r = '0;

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Busy      (Busy),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder)
`ifdef SEQ_DIV_ZERO_FLAG_EN
        ,
        .DivZero   (DivZero)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Result checker and hold-stability monitor.
    always @(negedge clk) begin
        if (rst) begin
            held_q = '0;
            held_r = '0;
        end else if (Done) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got Done=1, expected no pending result");
            end else begin
                mon_e = sb.pop_front();
                if (Quotient !== mon_e.q || Remainder !== mon_e.r) begin
                    n_err++;
                    $display("FAIL result: got Q=%0d R=%0d, expected Q=%0d R=%0d",
                             Quotient, Remainder, mon_e.q, mon_e.r);
                end
`ifdef SEQ_DIV_ZERO_FLAG_EN
                n_vec++;
                if (DivZero !== mon_e.dz) begin
                    n_err++;
                    $display("FAIL div_zero_flag: got %b, expected %b", DivZero, mon_e.dz);
                end
`endif
            end
            held_q = Quotient;
            held_r = Remainder;
        end else begin
            n_vec++;
            if (Quotient !== held_q || Remainder !== held_r) begin
                n_err++;
                $display("FAIL hold: got Q=%0d R=%0d, expected Q=%0d R=%0d",
                         Quotient, Remainder, held_q, held_r);
            end
        end
    end

    // Drive one Start pulse; expected result queued. Call with Busy=0.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        Dividend = a;
        Divisor  = b;
        Start    = 1'b1;
        sb.push_back(ref_div(a, b));
        @(posedge clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        bit got = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (Done) begin
                got = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL done_timeout: got no Done in %0d cycles, expected Done", max_cycles);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (Busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b, expected 0", Busy);
        end
        n_vec++;
        if (Done !== 1'b0) begin
            n_err++; $display("FAIL reset_done: got %b, expected 0", Done);
        end
        n_vec++;
        if (Quotient !== '0 || Remainder !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got Q=%0d R=%0d, expected 0 0", Quotient, Remainder);
        end
`ifdef SEQ_DIV_ZERO_FLAG_EN
        n_vec++;
        if (DivZero !== 1'b0) begin
            n_err++; $display("FAIL reset_divzero: got %b, expected 0", DivZero);
        end
`endif
    endtask

    task automatic test_latency();
        start_op(8'd200, 8'd7);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_vec++;
            if (Busy !== (k < 9) || Done !== (k == 9)) begin
                n_err++;
                $display("FAIL latency_k%0d: got Busy=%b Done=%b, expected Busy=%b Done=%b",
                         k, Busy, Done, (k < 9), (k == 9));
            end
        end
    endtask

    task automatic test_div_zero();
        start_op(8'd5, 8'd0);
        wait_done(20);
        n_vec++;
        if (Quotient !== 8'hFF || Remainder !== 8'd5) begin
            n_err++;
            $display("FAIL div_zero: got Q=%0d R=%0d, expected Q=255 R=5", Quotient, Remainder);
        end
        start_op(8'd6, 8'd3);
        wait_done(20);
`ifdef SEQ_DIV_ZERO_FLAG_EN
        n_vec++;
        if (DivZero !== 1'b0) begin
            n_err++; $display("FAIL div_zero_clear: got %b, expected 0", DivZero);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        int dones = 0;
        for (int i = 0; i < 3; i++) sb.push_back(ref_div(8'd255, 8'd16));
        Dividend = 8'd255;
        Divisor  = 8'd16;
        Start    = 1'b1;
        for (int i = 0; i < 40 && dones < 3; i++) begin
            @(negedge clk);
            cyc++;
            if (Done) begin
                n_vec++;
                if (cyc != 10) begin
                    n_err++;
                    $display("FAIL b2b_spacing: got %0d cycles, expected 10", cyc);
                end
                cyc = 0;
                dones++;
                if (dones == 3) Start = 1'b0;
            end
        end
        Start = 1'b0;
        n_vec++;
        if (dones != 3) begin
            n_err++; $display("FAIL b2b_count: got %0d Done pulses, expected 3", dones);
        end
    endtask

    task automatic test_busy_ignore();
        start_op(8'd100, 8'd9);
        @(negedge clk);
        Dividend = 8'd3;
        Divisor  = 8'd1;
        Start    = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        wait_done(20);
    endtask

    task automatic test_reset_abort();
        start_op(8'd100, 8'd9);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        n_vec++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Quotient !== '0 || Remainder !== '0) begin
            n_err++;
            $display("FAIL abort: got Busy=%b Done=%b Q=%0d R=%0d, expected 0 0 0 0",
                     Busy, Done, Quotient, Remainder);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n_vec++;
            if (Done !== 1'b0) begin
                n_err++; $display("FAIL abort_no_done: got Done=%b, expected 0", Done);
            end
        end
        start_op(8'd100, 8'd9);
        wait_done(20);
    endtask

    task automatic test_random();
        logic [W-1:0] edges [4];
        logic [W-1:0] a;
        logic [W-1:0] b;
        edges[0] = 8'd0;
        edges[1] = 8'd1;
        edges[2] = 8'd255;
        edges[3] = 8'd128;
        for (int i = 0; i < 1500; i++) begin
            a = (i % 5 == 0) ? edges[$urandom_range(0, 3)] : W'($urandom);
            b = (i % 3 == 0) ? edges[$urandom_range(0, 3)] : W'($urandom);
            start_op(a, b);
            wait_done(20);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_div_zero();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
        test_random();
        repeat (3) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
